// File: rtl/core_out_tx.sv
// core_out_tx: byte-output port; FIFO-buffered 8N1 UART transmitter, LSB first.
// Define CORE_OUT_PARITY_EN to insert an even-parity bit (8E1, 11-bit frames).
module core_out_tx #(
  parameter int CLK_PER_BIT = 868,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       OUTE,
  input  logic [7:0] OUTDATA,
  output logic       FULL,
  output logic       IDLE,
  output logic       OVF,
  output logic       TXD
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [AW:0]   DEPTH_C = FIFO_DEPTH[AW:0];
  localparam logic [CW-1:0] LAST_C  = CW'(CLK_PER_BIT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_n;
  logic          push, pop, nonempty;

  logic [2:0]    state, state_n;
  logic [CW-1:0] baud, baud_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shift, shift_n;
  logic          bit_end, txd_n;
  logic          par, par_n;

  // FULL is the registered flag, so a same-cycle pop never rescues a write.
  assign push     = OUTE && !FULL;
  assign nonempty = (count != '0);
  assign bit_end  = (baud == LAST_C);

  always_comb begin
    state_n = state;
    idx_n   = idx;
    shift_n = shift;
    par_n   = par;
    pop     = 1'b0;
    case (state)
      S_IDLE: if (nonempty) begin
        pop     = 1'b1;
        shift_n = mem[rd_ptr];
        par_n   = ^mem[rd_ptr];
        state_n = S_START;
      end
      S_START: if (bit_end) begin
        idx_n   = 3'd0;
        state_n = S_DATA;
      end
      S_DATA: if (bit_end) begin
        shift_n = {1'b0, shift[7:1]};
        idx_n   = idx + 3'd1;
        if (idx == 3'd7) begin
`ifdef CORE_OUT_PARITY_EN
          state_n = S_PAR;
`else
          state_n = S_STOP;
`endif
        end
      end
      S_PAR: if (bit_end) state_n = S_STOP;
      S_STOP: if (bit_end) begin
        if (nonempty) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr];
          par_n   = ^mem[rd_ptr];
          state_n = S_START;
        end else begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    baud_n = (state == S_IDLE || bit_end) ? '0 : baud + CW'(1);
    case (state_n)
      S_START: txd_n = 1'b0;
      S_DATA:  txd_n = shift_n[0];
`ifdef CORE_OUT_PARITY_EN
      S_PAR:   txd_n = par_n;
`endif
      default: txd_n = 1'b1;
    endcase
    count_n = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= OUTDATA;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      state  <= S_IDLE;
      baud   <= '0;
      idx    <= '0;
      shift  <= '0;
      par    <= 1'b0;
      TXD    <= 1'b1;
      FULL   <= 1'b0;
      IDLE   <= 1'b1;
      OVF    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_n;
      state <= state_n;
      baud  <= baud_n;
      idx   <= idx_n;
      shift <= shift_n;
      par   <= par_n;
      TXD   <= txd_n;
      FULL  <= (count_n == DEPTH_C);
      IDLE  <= (state_n == S_IDLE) && (count_n == '0);
      OVF   <= OVF | (OUTE & FULL);
    end
  end

endmodule

// File: tb/tb_core_out_tx.sv
// Directed bench for core_out_tx at CLK_PER_BIT=4, FIFO_DEPTH=4; cycle k is
// sampled 1 time unit after edge k-1.
module tb_core_out_tx;

  localparam int CPB = 4;
`ifdef CORE_OUT_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME_CYC = NB * CPB;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       OUTE = 1'b0;
  logic [7:0] OUTDATA = 8'h00;
  logic       FULL, IDLE, OVF, TXD;

  int checks = 0;
  int errors = 0;

  core_out_tx #(.CLK_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .OUTE(OUTE), .OUTDATA(OUTDATA),
    .FULL(FULL), .IDLE(IDLE), .OVF(OVF), .TXD(TXD)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Walks one frame from its (skip)th cycle, comparing TXD every cycle.
  task automatic frame_check(input logic [7:0] b, input int skip, input string tag);
    logic [10:0] fb;
    fb = '1;
    fb[0] = 1'b0;
    for (int i = 0; i < 8; i++) fb[i+1] = b[i];
`ifdef CORE_OUT_PARITY_EN
    fb[9] = ^b;
`endif
    for (int c = skip; c < FRAME_CYC; c++) begin
      chk($sformatf("%s_bit%0d_c%0d", tag, c / CPB, c % CPB), {31'd0, TXD}, {31'd0, fb[c / CPB]});
      if (c % CPB == 0) chk($sformatf("%s_busy%0d", tag, c / CPB), {31'd0, IDLE}, 32'd0);
      tick();
    end
  endtask

  task automatic quiet_check(input int n, input string tag);
    int lows;
    lows = 0;
    for (int i = 0; i < n; i++) begin
      if (TXD !== 1'b1 || IDLE !== 1'b1) lows++;
      tick();
    end
    chk(tag, lows, 0);
  endtask

  initial begin
    // reset
    tick(); tick();
    chk("rst_txd", {31'd0, TXD}, 1);
    chk("rst_idle", {31'd0, IDLE}, 1);
    chk("rst_full", {31'd0, FULL}, 0);
    chk("rst_ovf", {31'd0, OVF}, 0);
    RST_N = 1'b1;

    // single byte 0x55 from idle
    OUTE = 1'b1; OUTDATA = 8'h55;
    tick();                                   // cycle 1
    OUTE = 1'b0;
    chk("c1_txd", {31'd0, TXD}, 1);
    chk("c1_idle", {31'd0, IDLE}, 0);
    tick();                                   // cycle 2
    frame_check(8'h55, 0, "f55");
    chk("f55_idle_after", {31'd0, IDLE}, 1);
    chk("f55_txd_after", {31'd0, TXD}, 1);
    tick();

    // back-to-back 0xA3, 0x0F
    OUTE = 1'b1; OUTDATA = 8'hA3;
    tick();
    OUTDATA = 8'h0F;
    tick();
    OUTE = 1'b0;
    frame_check(8'hA3, 0, "fA3");
    frame_check(8'h0F, 0, "f0F");
    chk("b2b_idle_after", {31'd0, IDLE}, 1);
    tick();

`ifdef CORE_OUT_PARITY_EN
    OUTE = 1'b1; OUTDATA = 8'h07;
    tick(); OUTE = 1'b0; tick();
    frame_check(8'h07, 0, "p07");
    chk("p07_idle_after", {31'd0, IDLE}, 1);
    tick();
    OUTE = 1'b1; OUTDATA = 8'h03;
    tick(); OUTE = 1'b0; tick();
    frame_check(8'h03, 0, "p03");
    chk("p03_idle_after", {31'd0, IDLE}, 1);
    tick();
`endif

    // six strobes: five accepted, sixth dropped
    for (int k = 0; k < 6; k++) begin
      OUTE = 1'b1; OUTDATA = 8'h10 + 8'(k);
      if (k == 4) chk("full_c4", {31'd0, FULL}, 0);
      if (k == 5) chk("full_c5", {31'd0, FULL}, 1);
      if (k == 5) chk("ovf_c5", {31'd0, OVF}, 0);
      tick();
    end
    OUTE = 1'b0;                              // cycle 6
    chk("ovf_c6", {31'd0, OVF}, 1);
    frame_check(8'h10, 4, "q0");
    frame_check(8'h11, 0, "q1");
    frame_check(8'h12, 0, "q2");
    frame_check(8'h13, 0, "q3");
    frame_check(8'h14, 0, "q4");
    chk("q_idle_after", {31'd0, IDLE}, 1);
    quiet_check(3 * FRAME_CYC, "q_no_sixth_frame");
    chk("q_ovf_sticky", {31'd0, OVF}, 1);

    // reset mid-DATA with 3 bytes queued
    for (int k = 0; k < 4; k++) begin
      OUTE = 1'b1; OUTDATA = 8'hE0 + 8'(k);
      tick();
    end
    OUTE = 1'b0;                              // cycle 4
    chk("mid_count3", 32'(dut.count), 3);
    for (int i = 0; i < 16; i++) tick();      // cycle 20
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    chk("mid_txd", {31'd0, TXD}, 1);
    chk("mid_idle", {31'd0, IDLE}, 1);
    chk("mid_full", {31'd0, FULL}, 0);
    chk("mid_ovf", {31'd0, OVF}, 0);
    quiet_check(3 * FRAME_CYC, "mid_no_frames");

    // push in the last STOP cycle while count=2
    OUTE = 1'b1; OUTDATA = 8'h21;
    tick();
    OUTDATA = 8'h42;
    tick();
    OUTDATA = 8'h84;
    tick();
    OUTE = 1'b0;                              // cycle 3
    for (int i = 0; i < FRAME_CYC - 2; i++) tick();
    chk("pp_count_before", 32'(dut.count), 2);
    OUTE = 1'b1; OUTDATA = 8'hC6;             // last STOP cycle of frame 0x21
    tick();
    OUTE = 1'b0;
    chk("pp_count_after", 32'(dut.count), 2);
    chk("pp_full", {31'd0, FULL}, 0);
    frame_check(8'h42, 0, "pp42");
    frame_check(8'h84, 0, "pp84");
    frame_check(8'hC6, 0, "ppC6");
    chk("pp_idle_after", {31'd0, IDLE}, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_out_tx.md
# core_out_tx

Serial output port for the core's byte-output instruction. It is the transmit counterpart of the byte-input path that loads an 8-bit value into the low byte of an integer register. The core presents the low byte of a source register with a one-cycle strobe. The block queues it in a small FIFO and serializes it as 8N1 UART frames (LSB first) on TXD. FULL gives the core a stall signal, and OVF records any byte dropped while the FIFO was full.

## Interface
- CLK_PER_BIT, 868: clock cycles per serial bit (100 MHz / 115200); legal range ≥ 2.
- FIFO_DEPTH, 4: queue entries; power of two, ≥ 2.
---
- CLK  in  1  clock; all logic on rising edge.
- RST_N  in  1  synchronous, active-low reset.
- OUTE  in  1  write strobe; one byte is accepted per cycle it is high.
- OUTDATA  in  8  byte to send, sampled when OUTE=1.
- FULL  out  1  registered; high when the FIFO holds FIFO_DEPTH entries.
- IDLE  out  1  registered; high when the FIFO is empty and the serializer is in IDLE.
- OVF  out  1  sticky; set when OUTE=1 while FULL=1; cleared only by reset.
- TXD  out  1  registered serial line; idles high.

## Operation
- FIFO:
  - Storage is FIFO_DEPTH×8 with read/write pointers of log2(FIFO_DEPTH) bits, which wrap naturally.
  - The count is log2(FIFO_DEPTH)+1 bits.
  - Push when OUTE && !FULL. Pop when the serializer loads a byte.
  - Simultaneous push and pop: both pointers advance and the count is unchanged.
  - OUTE while FULL: the byte is dropped, OVF is set, and the FIFO is unchanged. This holds even if a pop occurs in the same cycle, because FULL is the registered value.
- Serializer FSM, states IDLE, START, DATA, STOP:
  - IDLE: TXD=1. If the FIFO is non-empty, pop the head into an 8-bit shift register and go to START.
  - START: TXD=0 for CLK_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: TXD = shift[0] for CLK_PER_BIT cycles, then shift right and increment the index. After index 7, go to STOP.
  - STOP: TXD=1 for CLK_PER_BIT cycles. On the last cycle: if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Baud counter:
  - Counts 0..CLK_PER_BIT-1, is cleared on every state or bit change, and is held at 0 in IDLE.
  - Width is $clog2(CLK_PER_BIT).
- Reset: all outputs and state are forced to their reset values. Mid-frame, the frame is aborted, TXD returns high at the next edge, and the FIFO is flushed.
- Reset values: TXD=1, FULL=0, IDLE=1, OVF=0, FSM=IDLE, pointers=0, count=0.

## Timing
- OUTE in cycle 0 with the block idle:
  - Edge 0 pushes the byte.
  - Edge 1 pops it and enters START.
  - TXD falls in cycle 2, so OUTE→start-bit latency is 2 cycles.
- Frame length: 10×CLK_PER_BIT cycles (11× with parity). Back-to-back frames have no gap between the stop bit and the next start bit.
- FULL, IDLE and OVF update at the edge after the causing event.
- IDLE deasserts in cycle 1 after a push in cycle 0. It reasserts one cycle after the last stop bit completes.
- Throughput: OUTE can be asserted every cycle until FULL. One entry frees per frame.

## Configuration
- CORE_OUT_PARITY_EN:
  - Defined: a PARITY state is inserted between DATA and STOP. TXD carries the even-parity bit (XOR of the 8 data bits) for CLK_PER_BIT cycles, and the frame is 11 bits.
  - Undefined: there is no PARITY state and the frame is 8N1, 10 bits.
  - Ports are identical in both builds.

## Test plan
- CLK_PER_BIT=4, OUTE with 0x55 while idle:
  - TXD=1 through cycle 1.
  - Cycles 2–5 = 0 (start bit).
  - Data bits 1,0,1,0,1,0,1,0, four cycles each.
  - Stop bit = 1 for cycles 38–41.
  - IDLE=1 from cycle 42.
- Bytes 0xA3 and 0x0F on consecutive cycles: the second start bit begins in the cycle immediately after the first frame's stop bit ends, with no idle cycle. Data bits appear LSB first.
- FIFO_DEPTH=4, six OUTE strobes on consecutive cycles 0–5 while idle:
  - Byte 0 is popped at edge 1.
  - FULL=1 in cycle 5.
  - Byte 5 is dropped and OVF=1 from cycle 6.
  - Exactly five frames are emitted; OVF stays 1.
- RST_N=0 for one cycle midway through the DATA bits of a frame with 3 bytes queued:
  - Next cycle: TXD=1, IDLE=1, FULL=0, OVF=0.
  - No further frames are sent.
- CORE_OUT_PARITY_EN build, byte 0x07: the parity bit is 1 and the frame is 44 cycles at CLK_PER_BIT=4. Byte 0x03 gives parity bit 0.
- Simultaneous push and pop with FIFO_DEPTH=4, with OUTE asserted in the cycle STOP completes and count=2: the count remains 2, FULL stays 0, and byte order is preserved.
